// File: rtl/arbitro_escrita_registradores_if.sv
// ---------------------------------------------------------------------------
// arbitro_escrita_registradores_if
//
// Bundles every non-clock signal of the register-file write-port arbiter.
//
//   ALU write-back     : alu_valid, alu_reg, alu_data  -> alu_ready
//   Load write-back    : mem_valid, mem_reg, mem_data  -> mem_ready
//   Decode scoreboard  : marca_valid, marca_reg (mark pending),
//                        read_register_1/2 -> busy_1/2
//   Register file port : regWrite, write_register, write_data
//
// Modports:
//   master - the pipeline side (requesters, decode, register file)
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface arbitro_escrita_registradores_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // ALU write-back requester
    logic                  alu_valid;
    logic [ADDR_WIDTH-1:0] alu_reg;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_ready;

    // Memory-load write-back requester
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_reg;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;

    // Decode-stage scoreboard access
    logic                  marca_valid;
    logic [ADDR_WIDTH-1:0] marca_reg;
    logic [ADDR_WIDTH-1:0] read_register_1;
    logic [ADDR_WIDTH-1:0] read_register_2;
    logic                  busy_1;
    logic                  busy_2;

    // Register-file write port
    logic                  regWrite;
    logic [ADDR_WIDTH-1:0] write_register;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output mem_valid, mem_reg, mem_data,
        input  mem_ready,
        output marca_valid, marca_reg, read_register_1, read_register_2,
        input  busy_1, busy_2,
        input  regWrite, write_register, write_data
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  mem_valid, mem_reg, mem_data,
        output mem_ready,
        input  marca_valid, marca_reg, read_register_1, read_register_2,
        output busy_1, busy_2,
        output regWrite, write_register, write_data
    );
endinterface

// File: rtl/arbitro_escrita_registradores.sv
// ---------------------------------------------------------------------------
// arbitro_escrita_registradores
//
// Shares the single write port of the MIPS register file between the ALU
// write-back path and the memory-load write-back path, using round-robin
// arbitration over a valid/ready handshake. The winning request is
// registered and presented to the register file one cycle later.
//
// A pending-write scoreboard (one bit per architectural register) is set by
// decode when it issues an instruction with a destination register and
// cleared when that register's write-back is accepted, so decode can detect
// read-after-write hazards on its two source operands.
//
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous, active-high reset
//   bus   - arbitro_escrita_registradores_if.slave (handshakes, scoreboard
//           access, register-file write port)
// ---------------------------------------------------------------------------
module arbitro_escrita_registradores #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    arbitro_escrita_registradores_if.slave    bus
);

    // Which requester wins when both are valid in the same cycle.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    prio_e                 prio_q,           prio_d;
    logic                  reg_write_q,      reg_write_d;
    logic [ADDR_WIDTH-1:0] write_register_q, write_register_d;
    logic [DATA_WIDTH-1:0] write_data_q,     write_data_d;
    logic [NUM_REGS-1:0]   pendente_q,       pendente_d;

    logic                  alu_grant;
    logic                  mem_grant;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] xfer_reg;
    logic [DATA_WIDTH-1:0] xfer_data;

    // -----------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on contention the pointer
    // decides. Both grants are combinational so a requester sees ready in
    // the same cycle it raises valid.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (bus.alu_valid && bus.mem_valid) begin
            alu_grant = (prio_q == PRIO_ALU);
            mem_grant = (prio_q == PRIO_MEM);
        end else begin
            alu_grant = bus.alu_valid;
            mem_grant = bus.mem_valid;
        end
    end

    assign xfer      = alu_grant || mem_grant;
    assign xfer_reg  = alu_grant ? bus.alu_reg  : bus.mem_reg;
    assign xfer_data = alu_grant ? bus.alu_data : bus.mem_data;

    // -----------------------------------------------------------------------
    // Pointer next state: after any accepted request the loser (or, for a
    // single requester, the other path) is favoured next time.
    // -----------------------------------------------------------------------
    always_comb begin
        prio_d = prio_q;
        if (alu_grant) begin
            prio_d = PRIO_MEM;
        end else if (mem_grant) begin
            prio_d = PRIO_ALU;
        end
    end

    // -----------------------------------------------------------------------
    // Register-file write port next state. Register 0 is hardwired to zero in
    // MIPS, so a write to it still goes through the handshake and updates the
    // index/data registers but never raises regWrite. Index and data simply
    // hold their last value while idle.
    // -----------------------------------------------------------------------
    always_comb begin
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (xfer) begin
            reg_write_d      = (xfer_reg != '0);
            write_register_d = xfer_reg;
            write_data_d     = xfer_data;
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard next state. The clear is applied before the set so that a
    // register retired and re-issued in the same cycle stays pending: the
    // new producer is still outstanding. Bit 0 is forced low because $zero
    // never has a pending writer.
    // -----------------------------------------------------------------------
    always_comb begin
        pendente_d = pendente_q;
        if (xfer) begin
            pendente_d[xfer_reg] = 1'b0;
        end
        if (bus.marca_valid && (bus.marca_reg != '0)) begin
            pendente_d[bus.marca_reg] = 1'b1;
        end
        pendente_d[0] = 1'b0;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset as a
    // whole; busy must read 0 for every register straight out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pendente_q <= '0;
        end else begin
            pendente_q <= pendente_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.alu_ready      = alu_grant;
    assign bus.mem_ready      = mem_grant;

    // No bypass: busy drops in the cycle the register file is being written,
    // so decode reads the new value one cycle after that.
    assign bus.busy_1         = pendente_q[bus.read_register_1];
    assign bus.busy_2         = pendente_q[bus.read_register_2];

    assign bus.regWrite       = reg_write_q;
    assign bus.write_register = write_register_q;
    assign bus.write_data     = write_data_q;

endmodule

// File: tb/tb_arbitro_escrita_registradores.sv
// ---------------------------------------------------------------------------
// tb_arbitro_escrita_registradores
//
// Directed bench for the register-file write-port arbiter. A reference model
// predicts the grants and scoreboard; each predicted transfer pushes the
// expected register-file write to a queue, popped and compared the cycle
// after acceptance.
// ---------------------------------------------------------------------------
module tb_arbitro_escrita_registradores;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct {
        logic          we;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } exp_t;

    logic clock;
    logic reset;

    arbitro_escrita_registradores_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    arbitro_escrita_registradores #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic          m_prio_mem;
    logic [NR-1:0] m_pend;
    exp_t          exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio_mem = 1'b0;
        m_pend     = '0;
        exp_q.delete();
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                         input logic kv, input logic [AW-1:0] kr);
        ifc.alu_valid   = av;
        ifc.alu_reg     = ar;
        ifc.alu_data    = ad;
        ifc.mem_valid   = mv;
        ifc.mem_reg     = mr;
        ifc.mem_data    = md;
        ifc.marca_valid = kv;
        ifc.marca_reg   = kr;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // One clock cycle: check combinational outputs mid-cycle against the
    // model, advance the model, then check the registered write port just
    // after the edge.
    task automatic tick();
        logic ag, mg;
        exp_t e;
        @(negedge clock);
        ag = ifc.alu_valid && (!ifc.mem_valid || !m_prio_mem);
        mg = ifc.mem_valid && (!ifc.alu_valid || m_prio_mem);
        check("alu_ready", 64'(ifc.alu_ready), 64'(ag));
        check("mem_ready", 64'(ifc.mem_ready), 64'(mg));
        check("busy_1", 64'(ifc.busy_1), 64'(m_pend[ifc.read_register_1]));
        check("busy_2", 64'(ifc.busy_2), 64'(m_pend[ifc.read_register_2]));
        if (ag) begin
            exp_q.push_back('{we: (ifc.alu_reg != 0), r: ifc.alu_reg, d: ifc.alu_data});
            m_pend[ifc.alu_reg] = 1'b0;
            m_prio_mem = 1'b1;
        end else if (mg) begin
            exp_q.push_back('{we: (ifc.mem_reg != 0), r: ifc.mem_reg, d: ifc.mem_data});
            m_pend[ifc.mem_reg] = 1'b0;
            m_prio_mem = 1'b0;
        end
        if (ifc.marca_valid && ifc.marca_reg != 0) m_pend[ifc.marca_reg] = 1'b1;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("regWrite", 64'(ifc.regWrite), 64'(e.we));
            check("write_register", 64'(ifc.write_register), 64'(e.r));
            check("write_data", 64'(ifc.write_data), 64'(e.d));
        end else begin
            check("regWrite_idle", 64'(ifc.regWrite), 64'(0));
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ifc.read_register_1 = '0;
        ifc.read_register_2 = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_regWrite", 64'(ifc.regWrite), 64'(0));
        check("rst_write_register", 64'(ifc.write_register), 64'(0));
        check("rst_write_data", 64'(ifc.write_data), 64'(0));
        check("rst_busy_1", 64'(ifc.busy_1), 64'(0));
        reset = 1'b0;

        // Single ALU write: reg 2 <- 7, then idle drops regWrite
        drive(1'b1, 5'd2, 32'd7, 1'b0, '0, '0, 1'b0, '0);
        tick();
        check("t1_wr_reg", 64'(ifc.write_register), 64'(2));
        check("t1_wr_data", 64'(ifc.write_data), 64'(7));
        idle();
        tick();
        check("t1_regWrite_low", 64'(ifc.regWrite), 64'(0));

        // Lone load write moves the pointer back to the ALU
        drive(1'b0, '0, '0, 1'b1, 5'd1, 32'h1111_0001, 1'b0, '0);
        tick();

        // Contention for 4 cycles: ALU, MEM, ALU, MEM with continuous regWrite
        drive(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd4, 32'h0000_0444, 1'b0, '0);
        tick(); check("t2_c1", 64'(ifc.write_register), 64'(3));
        tick(); check("t2_c2", 64'(ifc.write_register), 64'(4));
        tick(); check("t2_c3", 64'(ifc.write_register), 64'(3));
        tick(); check("t2_c4", 64'(ifc.write_register), 64'(4));
        check("t2_regWrite_c4", 64'(ifc.regWrite), 64'(1));
        idle();
        tick();

        // Mark reg 5 pending, observe busy_1, clear via load write
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
        tick();
        idle();
        ifc.read_register_1 = 5'd5;
        tick();
        check("t3_busy_1_set", 64'(ifc.busy_1), 64'(1));
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'hCAFE_0005, 1'b0, '0);
        tick();
        check("t3_busy_1_clr", 64'(ifc.busy_1), 64'(0));
        check("t3_regWrite", 64'(ifc.regWrite), 64'(1));
        check("t3_wr_reg", 64'(ifc.write_register), 64'(5));
        idle();
        tick();

        // Set and clear of reg 6 on the same edge: set wins
        ifc.read_register_2 = 5'd6;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd6);
        tick();
        drive(1'b1, 5'd6, 32'h0000_0066, 1'b0, '0, '0, 1'b1, 5'd6);
        tick();
        check("t4_busy_2_kept", 64'(ifc.busy_2), 64'(1));
        drive(1'b1, 5'd6, 32'h0000_0067, 1'b0, '0, '0, 1'b0, '0);
        tick();
        check("t4_busy_2_clr", 64'(ifc.busy_2), 64'(0));
        idle();
        tick();

        // Register 0: accepted, no regWrite, never pending
        ifc.read_register_1 = 5'd0;
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b1, 5'd0);
        tick();
        check("t5_regWrite_r0", 64'(ifc.regWrite), 64'(0));
        check("t5_wr_data_r0", 64'(ifc.write_data), 64'hFFFF_FFFF);
        check("t5_busy_r0", 64'(ifc.busy_1), 64'(0));
        idle();
        tick();

        // Reset mid-transfer with reg 7 pending and both requesters valid
        ifc.read_register_1 = 5'd7;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        tick();
        drive(1'b1, 5'd8, 32'h0000_0088, 1'b1, 5'd9, 32'h0000_0099, 1'b0, '0);
        tick();
        check("t6_pre_regWrite", 64'(ifc.regWrite), 64'(1));
        check("t6_pre_busy", 64'(ifc.busy_1), 64'(1));
        reset = 1'b1;
        #1;
        model_reset();
        check("t6_rst_regWrite", 64'(ifc.regWrite), 64'(0));
        check("t6_rst_busy", 64'(ifc.busy_1), 64'(0));
        check("t6_rst_wr_reg", 64'(ifc.write_register), 64'(0));
        #1;
        reset = 1'b0;
        tick();
        check("t6_first_alu", 64'(ifc.write_register), 64'(8));
        tick();
        check("t6_then_mem", 64'(ifc.write_register), 64'(9));
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_escrita_registradores.md
Name: arbitro_escrita_registradores

Overview:
Shares the single write port of the MIPS register file between two write-back requesters: the ALU result path and the memory-load path. It uses round-robin arbitration with a valid/ready handshake and drives the registered regWrite, write_register and write_data signals into the register file. It also keeps a pending-write scoreboard so the decode stage can detect read-after-write hazards on read_register_1 and read_register_2.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU write-back request
alu_reg  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
alu_ready  output  1  ALU request accepted this cycle (combinational)
mem_valid  input  1  load write-back request
mem_reg  input  ADDR_WIDTH  load destination register
mem_data  input  DATA_WIDTH  load data
mem_ready  output  1  load request accepted this cycle (combinational)
marca_valid  input  1  decode issues an instruction that will write marca_reg
marca_reg  input  ADDR_WIDTH  destination to mark pending
read_register_1  input  ADDR_WIDTH  decode source 1 index
read_register_2  input  ADDR_WIDTH  decode source 2 index
busy_1  output  1  read_register_1 has a pending write (combinational from scoreboard)
busy_2  output  1  read_register_2 has a pending write
regWrite  output  1  write enable to register file (registered)
write_register  output  ADDR_WIDTH  write index (registered)
write_data  output  DATA_WIDTH  write data (registered)

Behaviour:
- Asynchronous reset sets the following:
  - regWrite=0, write_register=0, write_data=0.
  - Scoreboard pendente[NUM_REGS-1:0]=0.
  - Priority pointer = ALU.
  - busy_1 and busy_2 therefore read 0.
- Arbitration:
  - Only alu_valid: alu_ready=1.
  - Only mem_valid: mem_ready=1.
  - Both valid: the requester named by the pointer gets ready=1 and the other gets 0.
  - After any accepted request, the pointer moves to the requester that did not win. A single-requester grant also updates the pointer.
  - Requesters hold valid, reg and data stable until ready.
- Handshake: a transfer occurs on the rising edge where valid&&ready. At most one transfer per cycle.
- Latency: a transfer at edge N drives regWrite=1, write_register=reg and write_data=data during cycle N+1. regWrite returns to 0 at edge N+1 unless another transfer occurs. Back-to-back transfers give a continuous regWrite=1.
- Register 0:
  - A request with reg=0 is accepted and counts for arbitration, but regWrite stays 0. write_register and write_data are still updated.
  - marca_reg=0 never sets pendente[0]; busy on index 0 is always 0.
- Scoreboard update at each edge:
  - Set: pendente[marca_reg] is set if marca_valid && marca_reg!=0.
  - Clear: pendente[r] is cleared for the register r of an accepted transfer.
  - Same register set and cleared in one edge: set wins, because a new producer is outstanding.
  - A set of a register that is already pending leaves it pending (no count, single outstanding writer per register assumed by the pipeline).
- busy_x = pendente[read_register_x], purely combinational. There is no bypass: the write becomes visible in the register file the cycle after the clear, so busy drops in the same cycle regWrite is asserted.
- Reset asserted mid-transfer: outputs and scoreboard clear immediately. Requests held at deassertion are arbitrated fresh, with the ALU favored.

Test Plan:
- Reset, then alu_valid=1, alu_reg=2, alu_data=7 for one cycle -> alu_ready=1 in that cycle; next cycle regWrite=1, write_register=2, write_data=7; cycle after that regWrite=0.
- alu_valid and mem_valid both held high for 4 cycles (alu_reg=3, mem_reg=4) -> grants alternate ALU, MEM, ALU, MEM; regWrite stays 1 for 4 consecutive cycles with write_register 3,4,3,4.
- marca_valid=1, marca_reg=5, then read_register_1=5 -> busy_1=1. Then mem transfer with mem_reg=5 -> busy_1=0 the cycle after acceptance, coinciding with regWrite=1 and write_register=5.
- Same edge: marca_reg=6 and accepted alu_reg=6 with pendente[6]=1 -> pendente[6] stays 1 and busy_2=1 for read_register_2=6.
- alu_valid with alu_reg=0 and alu_data=32'hFFFF_FFFF; marca_reg=0 -> alu_ready=1, regWrite stays 0, busy on index 0 = 0.
- Assert reset while both requesters are valid and pendente[7]=1 -> regWrite=0, busy=0 at once; after release the first grant goes to the ALU.
